// File: rtl/reg_file_clk_en_r_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_clk_en_r_pkg
// Shared defaults for the 16-bit multicycle RISC general-purpose register
// file. These are the default values of the register file and word-register
// parameters.
//   DATA_W_DEF  : default word width (16 bits)
//   ADDR_W_DEF  : default address width (3 bits, 8 GPRs)
//   DEPTH_DEF   : default number of implemented words
//   RST_VAL_DEF : default value every word takes on reset
// ---------------------------------------------------------------------------
package reg_file_clk_en_r_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 8;

  localparam logic [DATA_W_DEF-1:0] RST_VAL_DEF = 16'h0000;

endpackage : reg_file_clk_en_r_pkg

// File: rtl/reg_file_clk_en_r_reg.sv
// ---------------------------------------------------------------------------
// reg_nb_clk_en_r
// Single DATA_W-bit storage word. It updates on the falling edge of clk_n_i,
// and it has a synchronous reset and a load enable. This is the
// parametrised form of the original 16-bit clock-enabled register.
// Ports:
//   clk_n_i : clock; state changes on its falling edge
//   rst_i   : synchronous active-high reset to RST_VAL; beats en_i
//   en_i    : load enable; d_i is captured only when high
//   d_i     : data to load
//   q_o     : stored word
// ---------------------------------------------------------------------------
module reg_nb_clk_en_r
  import reg_file_clk_en_r_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VAL_DEF)
) (
  input  logic              clk_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] dataQ;
  logic [DATA_W-1:0] dataD;

  // Next-state selection. Reset has priority over the enable, and the word
  // holds its value when neither reset nor the enable is active.
  always_comb begin
    dataD = dataQ;
    if (rst_i) begin
      dataD = RST_VAL;
    end else if (en_i) begin
      dataD = d_i;
    end
  end

  // The word register updates on the falling edge of the clock.
  always_ff @(negedge clk_n_i) begin
    dataQ <= dataD;
  end

  assign q_o = dataQ;

endmodule : reg_nb_clk_en_r

// File: rtl/reg_file_clk_en_r.sv
// ---------------------------------------------------------------------------
// reg_file_clk_en_r
// Architectural GPR file for the multicycle 16-bit RISC. It holds DEPTH words
// of DATA_W bits and updates them on the falling edge of clk_n. It has a
// synchronous reset, a global clock enable, two combinational read ports
// with optional write-to-read bypass, and a debug port that is never
// bypassed.
// Ports:
//   clk_n            : clock; state changes on its falling edge
//   rst              : synchronous active-high reset; loads RST_VAL
//   clk_en           : global enable; 0 freezes all state except for reset
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : read port A (combinational, may be bypassed)
//   raddr_b/rdata_b  : read port B (combinational, may be bypassed)
//   dbg_addr/dbg_data: debug read port (combinational, never bypassed)
// Parameters:
//   DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W.
//   ZERO_REG=1 makes word 0 read as zero; writes to word 0 are ignored.
//   BYPASS=1 forwards a write in the current cycle to a read port whose
//   address matches.
// ---------------------------------------------------------------------------
module reg_file_clk_en_r
  import reg_file_clk_en_r_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter int                ZERO_REG = 1,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] RST_VAL  = DATA_W'(RST_VAL_DEF)
) (
  input  logic              clk_n,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] wordQ [DEPTH];
  logic [DATA_W-1:0] storedA;
  logic [DATA_W-1:0] storedB;
  logic [DATA_W-1:0] storedDbg;
  logic              waddrInRange;
  logic              writeValid;

  // Storage array. When ZERO_REG is set, word 0 is a constant instead of a
  // register, so it cannot hold anything other than zero. Each of the other
  // words loads only when its own address is decoded. Reset reaches every
  // word whatever the values of clk_en and we.
  for (genvar i = 0; i < DEPTH; i++) begin : gWord
    if ((ZERO_REG != 0) && (i == 0)) begin : gZero
      assign wordQ[i] = '0;
    end else begin : gReg
      logic wordEn;
      assign wordEn = clk_en & we & (waddr == ADDR_W'(i));
      reg_nb_clk_en_r #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
      ) uWord (
        .clk_n_i (clk_n),
        .rst_i   (rst),
        .en_i    (wordEn),
        .d_i     (wdata),
        .q_o     (wordQ[i])
      );
    end
  end

  // A write is "real" only when it will actually change storage. The same
  // condition gates the bypass. This prevents forwarding data for a write
  // that will be dropped: a reset cycle, a disabled clock, an out-of-range
  // address, or the hardwired zero word.
  always_comb begin
    waddrInRange = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) begin
        waddrInRange = 1'b1;
      end
    end
    writeValid = !rst && clk_en && we && waddrInRange &&
                 !((ZERO_REG != 0) && (waddr == '0));
  end

  // Stored-value read muxes. The default of zero covers addresses at or
  // above DEPTH. The constant word 0 covers the ZERO_REG case.
  always_comb begin
    storedA   = '0;
    storedB   = '0;
    storedDbg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) begin
        storedA = wordQ[i];
      end
      if (raddr_b == ADDR_W'(i)) begin
        storedB = wordQ[i];
      end
      if (dbg_addr == ADDR_W'(i)) begin
        storedDbg = wordQ[i];
      end
    end
  end

  // Forwarding for ports A and B. Each port is bypassed on its own address
  // match. The debug port always shows what is actually stored.
  always_comb begin
    rdata_a  = storedA;
    rdata_b  = storedB;
    dbg_data = storedDbg;
    if ((BYPASS != 0) && writeValid && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if ((BYPASS != 0) && writeValid && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule : reg_file_clk_en_r

// File: tb/tb_reg_file_clk_en_r.sv
// ---------------------------------------------------------------------------
// tb_reg_file_clk_en_r
// Both DUT instances share one set of input stimulus:
//   dut0: DEPTH=8, ZERO_REG=1, BYPASS=1, RST_VAL=16'h0000
//   dut1: DEPTH=6, ZERO_REG=0, BYPASS=0, RST_VAL=16'h00A0
// Inputs change one time unit after each falling edge. For each cycle, the
// expected outputs are pushed into a queue. A separate monitor empties the
// queue on the next rising edge and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_file_clk_en_r;

  typedef struct {
    int          sel;
    string       name;
    logic [15:0] exp;
  } chk_t;

  chk_t        scoreQ[$];
  int          total = 0;
  int          bad   = 0;
  int          stepNo = 0;

  logic        clkN = 1'b1;
  logic        rst, clkEn, we;
  logic [2:0]  waddr, raddrA, raddrB, dbgAddr;
  logic [15:0] wdata;
  logic [15:0] rdA0, rdB0, dbg0, rdA1, rdB1, dbg1;

  localparam logic [15:0] R1 = 16'h00A0;

  always #5 clkN = ~clkN;

  reg_file_clk_en_r #(
    .DATA_W(16), .ADDR_W(3), .DEPTH(8), .ZERO_REG(1), .BYPASS(1),
    .RST_VAL(16'h0000)
  ) dut0 (
    .clk_n(clkN), .rst(rst), .clk_en(clkEn), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddrA), .rdata_a(rdA0), .raddr_b(raddrB),
    .rdata_b(rdB0), .dbg_addr(dbgAddr), .dbg_data(dbg0)
  );

  reg_file_clk_en_r #(
    .DATA_W(16), .ADDR_W(3), .DEPTH(6), .ZERO_REG(0), .BYPASS(0),
    .RST_VAL(16'h00A0)
  ) dut1 (
    .clk_n(clkN), .rst(rst), .clk_en(clkEn), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddrA), .rdata_a(rdA1), .raddr_b(raddrB),
    .rdata_b(rdB1), .dbg_addr(dbgAddr), .dbg_data(dbg1)
  );

  function automatic logic [15:0] pickOutput(int sel);
    case (sel)
      0:       return rdA0;
      1:       return rdB0;
      2:       return dbg0;
      3:       return rdA1;
      4:       return rdB1;
      default: return dbg1;
    endcase
  endfunction

  // Waits for a falling edge, then drives one cycle of inputs.
  task automatic applyStimulus(input logic r, input logic en, input logic w,
                               input logic [2:0] wa, input logic [15:0] wd,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] da);
    @(negedge clkN);
    #1;
    rst = r; clkEn = en; we = w; waddr = wa; wdata = wd;
    raddrA = ra; raddrB = rb; dbgAddr = da;
    stepNo++;
  endtask

  // Pushes the six expected outputs for the inputs currently driven.
  task automatic checkOutput(input string tag,
                             input logic [15:0] a0, input logic [15:0] b0,
                             input logic [15:0] d0, input logic [15:0] a1,
                             input logic [15:0] b1, input logic [15:0] d1);
    logic [15:0] ev [6];
    string       nm [6];
    ev = '{a0, b0, d0, a1, b1, d1};
    nm = '{"dut0.rdata_a", "dut0.rdata_b", "dut0.dbg_data",
           "dut1.rdata_a", "dut1.rdata_b", "dut1.dbg_data"};
    for (int k = 0; k < 6; k++) begin
      chk_t c;
      c.sel  = k;
      c.name = $sformatf("%s/s%0d/%s", tag, stepNo, nm[k]);
      c.exp  = ev[k];
      scoreQ.push_back(c);
    end
  endtask

  // Monitor: empties the scoreboard at every rising edge, when the
  // combinational outputs have settled.
  initial begin
    forever begin
      @(posedge clkN);
      while (scoreQ.size() > 0) begin
        chk_t c;
        logic [15:0] act;
        c   = scoreQ.pop_front();
        act = pickOutput(c.sel);
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("[TB] FAIL %s actual=%h required=%h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clkEn = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddrA = '0; raddrB = '0; dbgAddr = '0;

    // Reset state: read every address through all ports.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e1;
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 3'(i));
      e1 = (i < 6) ? R1 : 16'h0000;
      checkOutput("rstRead", 16'h0, 16'h0, 16'h0, e1, e1, e1);
    end

    // Write and read back. The pre-edge values show bypass vs no bypass.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd5, 3'd3);
    checkOutput("wr3", 16'hBEEF, 16'h0, 16'h0, R1, R1, R1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 3'd5);
    checkOutput("wr5", 16'hBEEF, 16'h1234, 16'h0, 16'hBEEF, R1, R1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 3'd3);
    checkOutput("rdBack", 16'hBEEF, 16'h1234, 16'hBEEF,
                16'hBEEF, 16'h1234, 16'hBEEF);

    // Zero register: dut0 ignores the write, dut1 stores it.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0);
    checkOutput("wr0", 16'h0, 16'h0, 16'h0, R1, R1, R1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("rd0", 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Bypass on both ports; the debug port shows the stored value.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'h0001, 3'd2, 3'd2, 3'd2);
    checkOutput("wr2a", 16'h0001, 16'h0001, 16'h0, R1, R1, R1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2, 3'd2);
    checkOutput("byp2", 16'hA5A5, 16'hA5A5, 16'h0001,
                16'h0001, 16'h0001, 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 3'd2);
    checkOutput("post2", 16'hA5A5, 16'hA5A5, 16'hA5A5,
                16'hA5A5, 16'hA5A5, 16'hA5A5);

    // Clock enable low: the write and its bypass are both blocked.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 16'h5555, 3'd4, 3'd4, 3'd4);
    checkOutput("enLow", 16'h0, 16'h0, 16'h0, R1, R1, R1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 3'd4);
    checkOutput("enHold", 16'h0, 16'h0, 16'h0, R1, R1, R1);

    // Reset during a write: no bypass; storage returns to RST_VAL.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 16'h1111, 3'd6, 3'd3, 3'd6);
    checkOutput("wr6", 16'h1111, 16'hBEEF, 16'h0, 16'h0, 16'hBEEF, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 16'h7777, 3'd6, 3'd6, 3'd6);
    checkOutput("rstWr", 16'h1111, 16'h1111, 16'h1111, 16'h0, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd6, 3'd3, 3'd2);
    checkOutput("postRst", 16'h0, 16'h0, 16'h0, 16'h0, R1, R1);

    // Address 7: in range for dut0, out of range for dut1.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, 16'hCAFE, 3'd7, 3'd7, 3'd5);
    checkOutput("wr7", 16'hCAFE, 16'hCAFE, 16'h0, 16'h0, 16'h0, R1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 3'd7, 3'd5, 3'd7);
    checkOutput("rd7", 16'hCAFE, 16'h0, 16'hCAFE, 16'h0, R1, 16'h0);

    // Bounded drain of the scoreboard before the summary.
    for (int k = 0; k < 4 && scoreQ.size() > 0; k++) begin
      @(posedge clkN);
      #1;
    end
    if (scoreQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain actual=%0d pending required=0", scoreQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_clk_en_r

// File: doc/reg_file_clk_en_r.md
Name: reg_file_clk_en_r

Overview:
Parametrised register file for the multicycle 16-bit RISC datapath. It is the successor to the single 16-bit clock-enabled register: storage is generalised to DEPTH words of DATA_W bits, with synchronous reset and two combinational read ports. It adds an optional hardwired-zero register, optional write-to-read bypass, and a debug read port. The decode/writeback stages of the processor use it as the architectural GPR file.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 3, address width in bits
DEPTH, 8, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_W
ZERO_REG, 1, 1 = word 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port
RST_VAL, 0, value loaded into every word on reset (DATA_W bits)

Ports:
clk_n  input  1  clock; all state updates on its falling edge
rst  input  1  synchronous active-high reset, sampled on falling edge of clk_n
clk_en  input  1  global clock enable; 0 freezes all state, reset excepted
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr_a  input  ADDR_W  read address, port A
rdata_a  output  DATA_W  read data, port A (combinational)
raddr_b  input  ADDR_W  read address, port B
rdata_b  output  DATA_W  read data, port B (combinational)
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  DATA_W  debug read data (combinational, never bypassed)

Behaviour:
- Clock is clk_n, negedge-triggered; reset is synchronous and active-high, named rst. No other clock or async path.
- Priority at each falling edge: rst > (clk_en & we) > hold.
- rst=1: every word is loaded with RST_VAL regardless of clk_en or we. Word 0 stays 0 when ZERO_REG=1. A pending write in that cycle is dropped.
- Write: when clk_en=1, we=1 and rst=0, mem[waddr] <= wdata. The new value is visible on the read ports after that edge.
- Ignored writes: a write to waddr >= DEPTH is ignored. A write to waddr=0 is ignored when ZERO_REG=1.
- clk_en=0: no write occurs, even with we=1. Matches the legacy clock-enable semantics.
- Reads are combinational with zero latency: rdata_x = mem[raddr_x].
  - raddr_x >= DEPTH returns 0.
  - raddr_x=0 with ZERO_REG=1 returns 0.
- Bypass (BYPASS=1): if rst=0, clk_en=1, we=1, waddr=raddr_x and the write is not an ignored write, then rdata_x = wdata (same cycle). Ports A and B are bypassed independently; both may match.
- BYPASS=0: reads return the stored value until the falling edge.
- dbg_data follows the same address rules but is never bypassed.
- Output values after reset: all read ports return RST_VAL, except address 0 with ZERO_REG=1 and out-of-range addresses, which return 0.
- Reset mid-write (rst and we in the same cycle): storage equals RST_VAL after the edge. Bypass is suppressed while rst=1.
- Reads on the same address by all three ports are legal and return identical stored data.
- Initial state before the first reset is undefined (X in simulation). The bench must reset first.

Decomposition:
- Shared package/header: DATA_W/ADDR_W defaults for the 16-bit RISC, and RST_VAL default.
- Sub-module reg_nb_clk_en_r: a single DATA_W register with negedge clk_n, synchronous rst to RST_VAL, and enable. It is the parametrised generalisation of the 16-bit enabled register.
- The top generates DEPTH instances of reg_nb_clk_en_r; word 0 is a constant when ZERO_REG=1.
- The top contains write decode, read muxes and bypass logic.

Test Plan:
1. Reset then read: pulse rst for 1 edge with RST_VAL=16'h0000 -> rdata_a, rdata_b and dbg_data read 0 for all addresses 0..7.
2. Write/readback: write 16'hBEEF to addr 3 and 16'h1234 to addr 5. Set raddr_a=3, raddr_b=5 after the edges -> 16'hBEEF / 16'h1234.
3. Zero register: write 16'hFFFF to addr 0 with ZERO_REG=1 -> rdata_a=0 and dbg_data=0. With ZERO_REG=0 -> 16'hFFFF.
4. Bypass: mem[2]=16'h0001, present we=1, waddr=2, wdata=16'hA5A5, raddr_a=raddr_b=2 before the edge -> BYPASS=1 gives 16'hA5A5 on both pre-edge; BYPASS=0 gives 16'h0001 pre-edge and 16'hA5A5 post-edge. dbg_data=16'h0001 pre-edge in both cases.
5. Enable and reset priority:
   - we=1, clk_en=0, wdata=16'h5555 to addr 4 -> addr 4 unchanged.
   - rst=1 and we=1 with 16'h7777 to addr 6 in the same cycle -> addr 6 = RST_VAL.
6. Out of range: DEPTH=6, write 16'hCAFE to addr 7 -> no storage change, and a read of addr 7 returns 0.
